// File: rtl/rpn_axil_master_if.sv
// rpn_axil_master_if: AXI4-Lite bus bundle between the command-port initiator and the calculator slave.
interface rpn_axil_master_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/rpn_axil_master.sv
// rpn_axil_master: single-outstanding command port to AXI4-Lite initiator for the RPN calculator.
// Optional abort of unanswered transactions with RPN_AXIL_MASTER_TIMEOUT_EN.
module rpn_axil_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = 256
) (
  input  logic                          m00_axi_aclk,
  input  logic                          m00_axi_aresetn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_wdata,
  output logic                          rsp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          rsp_timeout,
  rpn_axil_master_if.master             m00_axi
);
  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA, RESP} state_t;
  state_t state;
  logic   busy;
  logic   tmo_hit;
  assign busy = state inside {WRITE, WRESP, RADDR, RDATA};
`ifdef RPN_AXIL_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  always_ff @(posedge m00_axi_aclk) begin
    if (!m00_axi_aresetn || state == IDLE) tmo_cnt <= '0;
    else if (busy) tmo_cnt <= tmo_cnt + 1'b1;
  end
  // Abort on the edge where the busy-cycle count would reach TIMEOUT_CYCLES.
  assign tmo_hit = busy && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0 & busy;
`endif
  always_ff @(posedge m00_axi_aclk) begin
    if (!m00_axi_aresetn) begin
      state           <= IDLE;
      cmd_ready       <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_rdata       <= '0;
      rsp_resp        <= '0;
      rsp_timeout     <= 1'b0;
      m00_axi.awaddr  <= '0;
      m00_axi.awprot  <= '0;
      m00_axi.awvalid <= 1'b0;
      m00_axi.wdata   <= '0;
      m00_axi.wstrb   <= '0;
      m00_axi.wvalid  <= 1'b0;
      m00_axi.bready  <= 1'b0;
      m00_axi.araddr  <= '0;
      m00_axi.arprot  <= '0;
      m00_axi.arvalid <= 1'b0;
      m00_axi.rready  <= 1'b0;
    end else if (tmo_hit) begin
      m00_axi.awvalid <= 1'b0;
      m00_axi.wvalid  <= 1'b0;
      m00_axi.bready  <= 1'b0;
      m00_axi.arvalid <= 1'b0;
      m00_axi.rready  <= 1'b0;
      rsp_resp        <= 2'b10;
      rsp_rdata       <= '0;
      rsp_timeout     <= 1'b1;
      rsp_valid       <= 1'b1;
      state           <= RESP;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              m00_axi.awaddr  <= cmd_addr;
              m00_axi.wdata   <= cmd_wdata;
              m00_axi.wstrb   <= '1;
              m00_axi.awvalid <= 1'b1;
              m00_axi.wvalid  <= 1'b1;
              state           <= WRITE;
            end else begin
              m00_axi.araddr  <= cmd_addr;
              m00_axi.arvalid <= 1'b1;
              state           <= RADDR;
            end
          end else cmd_ready <= 1'b1;
        end
        WRITE: begin
          // AW and W complete independently; a channel already accepted counts as done.
          if (m00_axi.awready) m00_axi.awvalid <= 1'b0;
          if (m00_axi.wready) m00_axi.wvalid <= 1'b0;
          if ((!m00_axi.awvalid || m00_axi.awready) && (!m00_axi.wvalid || m00_axi.wready)) begin
            m00_axi.bready <= 1'b1;
            state          <= WRESP;
          end
        end
        WRESP: begin
          if (m00_axi.bvalid && m00_axi.bready) begin
            m00_axi.bready <= 1'b0;
            rsp_resp       <= m00_axi.bresp;
            rsp_rdata      <= '0;
            rsp_timeout    <= 1'b0;
            rsp_valid      <= 1'b1;
            state          <= RESP;
          end
        end
        RADDR: begin
          if (m00_axi.arready) begin
            m00_axi.arvalid <= 1'b0;
            m00_axi.rready  <= 1'b1;
            state           <= RDATA;
          end
        end
        RDATA: begin
          if (m00_axi.rvalid && m00_axi.rready) begin
            m00_axi.rready <= 1'b0;
            rsp_resp       <= m00_axi.rresp;
            rsp_rdata      <= m00_axi.rdata;
            rsp_timeout    <= 1'b0;
            rsp_valid      <= 1'b1;
            state          <= RESP;
          end
        end
        RESP: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rpn_axil_master.sv
// tb_rpn_axil_master: directed bench with an RPN calculator slave model and configurable AXI stalls.
module tb_rpn_axil_master;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int TMO = 16;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic cmd_ready, rsp_valid, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [1:0] rsp_resp;
  int checks = 0;
  int fails = 0;
  int aw_delay = 0;
  logic ar_en = 1'b1;
  logic r_en = 1'b1;
  logic [1:0] bresp_cfg = 2'b00;
  always #5 clk = ~clk;
  rpn_axil_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  rpn_axil_master #(.C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .m00_axi_aclk(clk), .m00_axi_aresetn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout), .m00_axi(bus)
  );
  // Calculator slave: ready is registered one cycle after valid (plus aw_delay on AW).
  int aw_cnt, sp;
  logic aw_done, w_done;
  logic [AW-1:0] aw_addr_q, wa;
  logic [DW-1:0] w_data_q, wd, operand;
  logic [DW-1:0] stk [8];
  logic aw_hs, w_hs, ar_hs;
  assign aw_hs = bus.awvalid && bus.awready;
  assign w_hs = bus.wvalid && bus.wready;
  assign ar_hs = bus.arvalid && bus.arready;
  assign wa = aw_hs ? bus.awaddr : aw_addr_q;
  assign wd = w_hs ? bus.wdata : w_data_q;
  always @(posedge clk) begin
    if (!rstn) begin
      bus.awready <= 1'b0; bus.wready <= 1'b0; bus.arready <= 1'b0;
      bus.bvalid <= 1'b0; bus.rvalid <= 1'b0; bus.bresp <= 2'b00; bus.rresp <= 2'b00; bus.rdata <= '0;
      aw_cnt <= 0; aw_done <= 1'b0; w_done <= 1'b0; aw_addr_q <= '0; w_data_q <= '0;
      operand <= '0; sp <= 0;
    end else begin
      bus.awready <= bus.awvalid && !bus.awready && aw_cnt >= aw_delay;
      if (bus.awvalid && !bus.awready && aw_cnt < aw_delay) aw_cnt <= aw_cnt + 1;
      bus.wready <= bus.wvalid && !bus.wready;
      if (aw_hs) begin aw_done <= 1'b1; aw_addr_q <= bus.awaddr; end
      if (w_hs) begin w_done <= 1'b1; w_data_q <= bus.wdata; end
      if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
      if ((aw_done || aw_hs) && (w_done || w_hs) && !bus.bvalid) begin
        bus.bvalid <= 1'b1; bus.bresp <= bresp_cfg;
        aw_done <= 1'b0; w_done <= 1'b0; aw_cnt <= 0;
        if (wa[3:2] == 2'd0) operand <= wd;
        else if (wa[3:2] == 2'd1) begin
          if (wd == 32'd1) sp <= 0;
          else if (wd == 32'd2) begin stk[sp] <= operand; sp <= sp + 1; end
          else if (wd == 32'h8) begin stk[sp-2] <= stk[sp-2] + stk[sp-1]; sp <= sp - 1; end
          else if (wd == 32'h20) begin stk[sp-2] <= stk[sp-2] * stk[sp-1]; sp <= sp - 1; end
        end
      end
      bus.arready <= bus.arvalid && !bus.arready && ar_en;
      if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
      if (ar_hs && r_en) begin
        bus.rvalid <= 1'b1; bus.rresp <= 2'b00;
        bus.rdata <= (bus.araddr[3:2] == 2'd0) ? operand :
                     (bus.araddr[3:2] == 2'd2 && sp > 0) ? stk[sp-1] : '0;
      end
    end
  end
  task automatic cyc();
    @(posedge clk); #1;
  endtask
  // Drives one command; returns at the cycle rsp_valid is seen (or after a 200-cycle bound).
  // lat counts cycles from the accept cycle to the response cycle.
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output int wait_n, output logic [8:0] vld, output int lat);
    wait_n = 0;
    while (!cmd_ready && wait_n < 50) begin cyc(); wait_n++; end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    cyc();
    cmd_valid = 1'b0;
    vld = {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, bus.wstrb};
    lat = 1;
    while (!rsp_valid && lat < 200) begin cyc(); lat++; end
  endtask
  task automatic test_reset();
    repeat (3) cyc();
    checks++;
    if ({cmd_ready, rsp_valid, bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready} !== 7'b0) begin
      fails++; $display("FAIL reset_outputs: got %b want 0000000", {cmd_ready, rsp_valid, bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready});
    end
    checks++;
    if ({bus.awaddr, bus.wdata, bus.wstrb, bus.araddr, rsp_rdata, rsp_resp, rsp_timeout} !== '0) begin
      fails++; $display("FAIL reset_data: addr/data/rsp registers not zero");
    end
    rstn = 1'b1;
    cyc();
    checks++;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready); end
    checks++;
    if ({rsp_valid, bus.awvalid, bus.wvalid, bus.arvalid} !== 4'b0) begin
      fails++; $display("FAIL reset_release_valids: got %b want 0000", {rsp_valid, bus.awvalid, bus.wvalid, bus.arvalid});
    end
  endtask
  task automatic test_write_read();
    int w, lat;
    logic [8:0] vld;
    issue(1'b1, 4'h0, 32'h1234_0000, w, vld, lat);
    checks++;
    if (vld !== 9'b11000_1111) begin fails++; $display("FAIL wr_accept_bus: got %b want 110001111", vld); end
    checks++;
    if (lat !== 4) begin fails++; $display("FAIL wr_latency: got %0d want 4", lat); end
    checks++;
    if ({rsp_resp, rsp_rdata, rsp_timeout} !== 35'b0) begin
      fails++; $display("FAIL wr_rsp: resp=%b rdata=%h tmo=%b want 0/0/0", rsp_resp, rsp_rdata, rsp_timeout);
    end
    issue(1'b0, 4'h0, 32'h0, w, vld, lat);
    checks++;
    if (vld[8:4] !== 5'b00100) begin fails++; $display("FAIL rd_accept_bus: got %b want 00100", vld[8:4]); end
    checks++;
    if (lat !== 4) begin fails++; $display("FAIL rd_latency: got %0d want 4", lat); end
    checks++;
    if (rsp_rdata !== 32'h1234_0000 || rsp_resp !== 2'b00) begin
      fails++; $display("FAIL rd_data: got %h/%b want 12340000/00", rsp_rdata, rsp_resp);
    end
    cyc();
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin fails++; $display("FAIL rsp_single_pulse: valid/ready got %b want 01", {rsp_valid, cmd_ready}); end
    checks++;
    if (rsp_rdata !== 32'h1234_0000) begin fails++; $display("FAIL rsp_hold: got %h want 12340000", rsp_rdata); end
  endtask
  task automatic test_back_to_back();
    logic [AW-1:0] ca [9] = '{4'h4, 4'h0, 4'h4, 4'h0, 4'h4, 4'h4, 4'h0, 4'h4, 4'h4};
    logic [DW-1:0] cd [9] = '{32'h1, 32'h10, 32'h2, 32'h15, 32'h2, 32'h8, 32'h21, 32'h2, 32'h20};
    int w, lat;
    logic [8:0] vld;
    for (int i = 0; i < 9; i++) begin
      issue(1'b1, ca[i], cd[i], w, vld, lat);
      checks++;
      if (rsp_resp !== 2'b00 || lat !== 4) begin
        fails++; $display("FAIL calc_write_%0d: resp=%b lat=%0d want 00/4", i, rsp_resp, lat);
      end
      if (i > 0) begin
        checks++;
        if (w !== 1) begin fails++; $display("FAIL b2b_accept_%0d: waited %0d cycles want 1", i, w); end
      end
    end
    issue(1'b0, 4'h8, 32'h0, w, vld, lat);
    checks++;
    if (w !== 1) begin fails++; $display("FAIL b2b_accept_read: waited %0d cycles want 1", w); end
    checks++;
    if (rsp_rdata !== 32'h4C5 || rsp_resp !== 2'b00) begin
      fails++; $display("FAIL calc_result: got %h/%b want 000004c5/00", rsp_rdata, rsp_resp);
    end
  endtask
  task automatic test_slow_aw();
    int aw_hi = 0, w_hi = 0, early_b = 0, n = 0;
    aw_delay = 3; bresp_cfg = 2'b10;
    while (!cmd_ready && n < 50) begin cyc(); n++; end
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h0; cmd_wdata = 32'hA5A5_0001;
    cyc();
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 60) begin
      if (bus.awvalid) aw_hi++;
      if (bus.wvalid) w_hi++;
      if (bus.bready && (bus.awvalid || bus.wvalid)) early_b++;
      cyc(); n++;
    end
    checks++;
    if (w_hi !== 2) begin fails++; $display("FAIL slow_w_cycles: got %0d want 2", w_hi); end
    checks++;
    if (aw_hi !== 5) begin fails++; $display("FAIL slow_aw_cycles: got %0d want 5", aw_hi); end
    checks++;
    if (early_b !== 0) begin fails++; $display("FAIL slow_bready_early: got %0d want 0", early_b); end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_resp !== 2'b10) begin
      fails++; $display("FAIL slow_bresp: valid=%b resp=%b want 1/10", rsp_valid, rsp_resp);
    end
    aw_delay = 0; bresp_cfg = 2'b00;
  endtask
  task automatic test_reset_mid();
    int n = 0, w, lat;
    logic [8:0] vld;
    r_en = 1'b0;
    while (!cmd_ready && n < 50) begin cyc(); n++; end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h0;
    cyc();
    cmd_valid = 1'b0;
    n = 0;
    while (!bus.rready && n < 20) begin cyc(); n++; end
    checks++;
    if (bus.rready !== 1'b1) begin fails++; $display("FAIL mid_reach_rdata: rready got %b want 1", bus.rready); end
    rstn = 1'b0;
    cyc();
    checks++;
    if ({bus.arvalid, bus.rready, rsp_valid, cmd_ready} !== 4'b0) begin
      fails++; $display("FAIL mid_reset_drop: got %b want 0000", {bus.arvalid, bus.rready, rsp_valid, cmd_ready});
    end
    rstn = 1'b1; r_en = 1'b1;
    cyc();
    issue(1'b0, 4'h0, 32'h0, w, vld, lat);
    checks++;
    if (lat !== 4 || rsp_rdata !== 32'h0 || rsp_resp !== 2'b00) begin
      fails++; $display("FAIL mid_recover_read: lat=%0d data=%h resp=%b want 4/0/00", lat, rsp_rdata, rsp_resp);
    end
  endtask
  task automatic test_timeout();
    int n = 0, w, lat;
    logic [8:0] vld;
    ar_en = 1'b0;
    while (!cmd_ready && n < 50) begin cyc(); n++; end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h8;
    cyc();
    cmd_valid = 1'b0;
`ifdef RPN_AXIL_MASTER_TIMEOUT_EN
    lat = 1;
    while (!rsp_valid && lat < 100) begin cyc(); lat++; end
    checks++;
    if (lat !== TMO + 1) begin fails++; $display("FAIL tmo_latency: got %0d want %0d", lat, TMO + 1); end
    checks++;
    if ({rsp_resp, rsp_timeout, bus.arvalid} !== 4'b1010 || rsp_rdata !== '0) begin
      fails++; $display("FAIL tmo_rsp: resp=%b tmo=%b arvalid=%b rdata=%h want 10/1/0/0", rsp_resp, rsp_timeout, bus.arvalid, rsp_rdata);
    end
    ar_en = 1'b1;
    issue(1'b0, 4'h0, 32'h0, w, vld, lat);
    checks++;
    if (lat !== 4 || rsp_timeout !== 1'b0 || rsp_resp !== 2'b00) begin
      fails++; $display("FAIL tmo_clear: lat=%0d tmo=%b resp=%b want 4/0/00", lat, rsp_timeout, rsp_resp);
    end
`else
    n = 0;
    repeat (120) begin
      cyc();
      if (bus.arvalid && !rsp_valid) n++;
    end
    checks++;
    if (n !== 120) begin fails++; $display("FAIL notmo_arvalid_held: %0d of 120 cycles", n); end
    checks++;
    if (rsp_timeout !== 1'b0) begin fails++; $display("FAIL notmo_flag: got %b want 0", rsp_timeout); end
    rstn = 1'b0;
    cyc();
    rstn = 1'b1; ar_en = 1'b1;
    cyc();
    issue(1'b0, 4'h0, 32'h0, w, vld, lat);
    checks++;
    if (lat !== 4 || rsp_resp !== 2'b00) begin fails++; $display("FAIL notmo_recover: lat=%0d resp=%b want 4/00", lat, rsp_resp); end
`endif
  endtask
  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_slow_aw();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/rpn_axil_master.md
Name: rpn_axil_master

Overview:
- AXI4-Lite initiator that converts a simple single-outstanding command port into AXI4-Lite write and read transactions.
- Used by on-chip sequencers to drive the RPN calculator register map without the PS:
  - word 0 = operand
  - word 1 = command (1 reset, 2 push, 8 add, 0x20 multiply)
  - word 2 = stack top
- Sits between a local controller and the calculator's S00_AXI slave port.

Parameters:
- C_M_AXI_ADDR_WIDTH, 4, AXI address width in bits; byte address, word aligned.
- C_M_AXI_DATA_WIDTH, 32, AXI data width in bits; only 32 supported.
- TIMEOUT_CYCLES, 256, cycles before an unanswered transaction is aborted (used only with the optional feature).

Ports:
- m00_axi_aclk  in  1  clock
- m00_axi_aresetn  in  1  synchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  byte address
- cmd_wdata  in  32  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  read data; 0 after a write
- rsp_resp  out  2  BRESP/RRESP captured from slave
- rsp_timeout  out  1  completion caused by timeout
- m00_axi_awaddr  out  C_M_AXI_ADDR_WIDTH
- m00_axi_awprot  out  3  constant 3'b000
- m00_axi_awvalid  out  1
- m00_axi_awready  in  1
- m00_axi_wdata  out  32
- m00_axi_wstrb  out  4  4'b1111 on writes
- m00_axi_wvalid  out  1
- m00_axi_wready  in  1
- m00_axi_bresp  in  2
- m00_axi_bvalid  in  1
- m00_axi_bready  out  1
- m00_axi_araddr  out  C_M_AXI_ADDR_WIDTH
- m00_axi_arprot  out  3  constant 3'b000
- m00_axi_arvalid  out  1
- m00_axi_arready  in  1
- m00_axi_rdata  in  32
- m00_axi_rresp  in  2
- m00_axi_rvalid  in  1
- m00_axi_rready  out  1

Behaviour:
- Reset (synchronous, sampled at rising edge while m00_axi_aresetn=0):
  - state=IDLE
  - all AXI valid/ready outputs 0, addresses/wdata/wstrb 0
  - rsp_valid=0, rsp_rdata=0, rsp_resp=0, rsp_timeout=0
  - cmd_ready=0 during reset; 1 in IDLE thereafter.
- FSM states: IDLE, WRITE, WRESP, RADDR, RDATA, RESP. All outputs registered.
- IDLE: cmd_ready=1.
  - On cmd_valid&cmd_ready: latch addr/wdata.
  - Write: next edge assert awvalid=1 and wvalid=1 together, wstrb=4'b1111, go WRITE.
  - Read: next edge assert arvalid=1, go RADDR.
- WRITE:
  - awvalid drops the edge after awready is sampled high; wvalid drops the edge after wready is sampled high; each is independent, any order, same cycle allowed.
  - When both have been accepted, assert bready=1 and go WRESP. AW/W addresses and data are held stable while valid.
- WRESP: on bvalid&bready, capture bresp, deassert bready, go RESP.
- RADDR: on arready, deassert arvalid, assert rready=1, go RDATA.
- RDATA: on rvalid&rready, capture rdata/rresp, deassert rready, go RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. cmd_ready=0 in RESP.
- Latency with zero-wait slave:
  - write: cmd accept to rsp_valid = 4 cycles
  - read: cmd accept to rsp_valid = 4 cycles
- Back-to-back commands: next cmd accepted the cycle after rsp_valid.
- Only one transaction outstanding; never both read and write active.
- rsp_rdata/rsp_resp hold until the next completion.
- bvalid/rvalid arriving when not expected is ignored (no state change).
- Reset mid-transaction: all valids/readies drop at that edge, no rsp_valid generated, FSM to IDLE. The slave is assumed reset on the same net.
- cmd_valid while cmd_ready=0 is ignored; the caller holds it.

Optional Feature:
- Macro: RPN_AXIL_MASTER_TIMEOUT_EN
- Enabled:
  - A counter clears on command accept and increments every cycle in WRITE/WRESP/RADDR/RDATA.
  - When it reaches TIMEOUT_CYCLES: drop all AXI valid/ready, rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0, go RESP.
  - rsp_timeout clears on the next completion.
- Disabled: no counter, the FSM waits indefinitely, rsp_timeout tied 0.

Test Plan:
- Reset held 3 cycles then released -> all AXI valids 0, cmd_ready=1 one cycle after release, no rsp_valid.
- Write addr 0x0 data 0x12340000, then read 0x0 -> awvalid/wvalid asserted together, wstrb=4'hF; rsp_resp=0; read returns rsp_rdata=0x12340000 with rsp_valid single pulse.
- Driving the calculator:
  - commands:
    - write 0x4=1
    - write 0x0=0x10
    - write 0x4=2
    - write 0x0=0x15
    - write 0x4=2
    - write 0x4=8
    - write 0x0=0x21
    - write 0x4=2
    - write 0x4=0x20
    - read 0x8
  - rsp_rdata=0x4C5 (0x25*0x21).
- Slave model with awready delayed 3 cycles and wready 0 delay, then bresp=2'b10 -> wvalid drops after 1 cycle, awvalid after 3, bready rises only after both, rsp_resp=2'b10.
- Reset asserted while in RDATA (rvalid held 0) -> next edge arvalid/rready=0, no rsp_valid, subsequent read 0x0 completes normally.
- With RPN_AXIL_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never asserts arready -> rsp_valid after 16 cycles, rsp_resp=2'b10, rsp_timeout=1, arvalid 0; without the macro arvalid remains 1 for 100+ cycles.
